// File: rtl/stamofu_split_addr_pipeline.sv
// Store/AMO/fence address pipeline: operand collect (OC) then request (REQ), with word-crossing
// stores split into two REQ beats. Optional input skid register: STAMOFU_SPLIT_ADDR_PIPELINE_SKID_EN.
module stamofu_split_addr_pipeline #(
    parameter int PRF_BANK_COUNT     = 4,
    parameter int LOG_PRF_BANK_COUNT = 2,
    parameter int LOG_CQ_ENTRIES     = 4,
    parameter int VPN_WIDTH          = 20,
    parameter int PO_WIDTH           = 12
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          issue_valid,
    input  logic                          issue_is_store,
    input  logic                          issue_is_amo,
    input  logic                          issue_is_fence,
    input  logic [3:0]                    issue_op,
    input  logic [11:0]                   issue_imm12,
    input  logic                          issue_A_forward,
    input  logic                          issue_A_is_zero,
    input  logic [LOG_PRF_BANK_COUNT-1:0] issue_A_bank,
    input  logic                          issue_B_forward,
    input  logic                          issue_B_is_zero,
    input  logic [LOG_PRF_BANK_COUNT-1:0] issue_B_bank,
    input  logic [LOG_CQ_ENTRIES-1:0]     issue_cq_index,
    output logic                          issue_ready,
    input  logic                          A_reg_read_ack,
    input  logic                          A_reg_read_port,
    input  logic                          B_reg_read_ack,
    input  logic                          B_reg_read_port,
    input  logic [PRF_BANK_COUNT*2*32-1:0] reg_read_data_by_bank_by_port,
    input  logic [PRF_BANK_COUNT*32-1:0]  forward_data_by_bank,
    output logic                          REQ_valid,
    output logic                          REQ_is_mq,
    output logic                          REQ_misaligned,
    output logic                          REQ_misaligned_exception,
    output logic [VPN_WIDTH-1:0]          REQ_VPN,
    output logic [PO_WIDTH-3:0]           REQ_PO_word,
    output logic [3:0]                    REQ_byte_mask,
    output logic [31:0]                   REQ_write_data,
    output logic [LOG_CQ_ENTRIES-1:0]     REQ_cq_index,
    input  logic                          REQ_ack
);
    localparam int WADDR_W = VPN_WIDTH + PO_WIDTH - 2;

    typedef struct packed {
        logic                          is_store;
        logic                          is_amo;
        logic                          is_fence;
        logic [1:0]                    size;
        logic [11:0]                   imm;
        logic                          a_fwd;
        logic                          a_zero;
        logic [LOG_PRF_BANK_COUNT-1:0] a_bank;
        logic                          b_fwd;
        logic                          b_zero;
        logic [LOG_PRF_BANK_COUNT-1:0] b_bank;
        logic [LOG_CQ_ENTRIES-1:0]     cq;
    } op_t;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BEAT1 = 2'd1, S_BEAT2 = 2'd2} split_state_t;

    // Returns {ready, value}; a captured operand stays ready regardless of later acks.
    function automatic logic [32:0] pick_operand(
        input logic                          zero,
        input logic                          fwd,
        input logic                          have,
        input logic                          first,
        input logic                          ack,
        input logic                          fence,
        input logic [LOG_PRF_BANK_COUNT-1:0] bank,
        input logic                          port,
        input logic [31:0]                   held,
        input logic [PRF_BANK_COUNT*32-1:0]  fwd_vec,
        input logic [PRF_BANK_COUNT*64-1:0]  rr_vec
    );
        logic        ready;
        logic [31:0] value;
        if (zero) begin
            ready = 1'b1;
            value = 32'd0;
        end else if (have) begin
            ready = 1'b1;
            value = held;
        end else if (fwd) begin
            ready = first;
            value = fwd_vec[32*bank +: 32];
        end else begin
            ready = ack;
            value = rr_vec[64*bank + 32*port +: 32];
        end
        return {ready | fence, value};
    endfunction

    op_t          in_op_s, oc_in_s, oc_op_r;
    logic         oc_valid_r, oc_first_r, a_have_r, b_have_r;
    logic [31:0]  a_val_r, b_val_r, a_value_s, b_value_s;
    logic         a_ready_s, b_ready_s;
    logic         issue_fire_s, oc_accept_s, oc_load_s, oc_fire_s;
    logic [31:0]  addr_s;
    logic [7:0]   base_s, mask8_s;
    logic [63:0]  data64_s;
    logic         mis_s, last_beat_s, req_free_s;
    logic [WADDR_W-1:0] waddr_inc_s;

    split_state_t state_r, state_n;
    logic         valid_r, valid_n, is_mq_r, is_mq_n, mis_r, mis_n, exc_r, exc_n, split_r, split_n;
    logic [VPN_WIDTH-1:0]      vpn_r, vpn_n;
    logic [PO_WIDTH-3:0]       po_r, po_n;
    logic [3:0]                mask_r, mask_n, hi_mask_r, hi_mask_n;
    logic [31:0]               data_r, data_n, hi_data_r, hi_data_n;
    logic [LOG_CQ_ENTRIES-1:0] cq_r, cq_n;

    assign in_op_s = '{is_store: issue_is_store, is_amo: issue_is_amo, is_fence: issue_is_fence,
                       size: issue_op[1:0], imm: issue_imm12,
                       a_fwd: issue_A_forward, a_zero: issue_A_is_zero, a_bank: issue_A_bank,
                       b_fwd: issue_B_forward, b_zero: issue_B_is_zero, b_bank: issue_B_bank,
                       cq: issue_cq_index};

    assign {a_ready_s, a_value_s} = pick_operand(oc_op_r.a_zero, oc_op_r.a_fwd, a_have_r, oc_first_r,
        A_reg_read_ack, oc_op_r.is_fence, oc_op_r.a_bank, A_reg_read_port, a_val_r,
        forward_data_by_bank, reg_read_data_by_bank_by_port);
    assign {b_ready_s, b_value_s} = pick_operand(oc_op_r.b_zero, oc_op_r.b_fwd, b_have_r, oc_first_r,
        B_reg_read_ack, oc_op_r.is_fence, oc_op_r.b_bank, B_reg_read_port, b_val_r,
        forward_data_by_bank, reg_read_data_by_bank_by_port);

    assign last_beat_s  = (state_r == S_BEAT2) || (state_r == S_BEAT1 && !split_r);
    assign req_free_s   = !valid_r || (REQ_ack && last_beat_s);
    assign oc_fire_s    = oc_valid_r && a_ready_s && b_ready_s && req_free_s;
    assign oc_accept_s  = !oc_valid_r || oc_fire_s;
    assign issue_fire_s = issue_valid && issue_ready;

`ifdef STAMOFU_SPLIT_ADDR_PIPELINE_SKID_EN
    op_t  skid_r;
    logic skid_valid_r;

    assign issue_ready = !skid_valid_r;
    assign oc_in_s     = skid_valid_r ? skid_r : in_op_s;
    assign oc_load_s   = oc_accept_s && (skid_valid_r || issue_fire_s);

    // Skid register: parks an accepted op only when OC cannot take it this cycle.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            skid_valid_r <= 1'b0;
            skid_r       <= '0;
        end else if (issue_fire_s && !oc_accept_s) begin
            skid_valid_r <= 1'b1;
            skid_r       <= in_op_s;
        end else if (oc_accept_s) begin
            skid_valid_r <= 1'b0;
        end else begin
            skid_valid_r <= skid_valid_r;
        end
    end
`else
    assign issue_ready = oc_accept_s;
    assign oc_in_s     = in_op_s;
    assign oc_load_s   = issue_fire_s;
`endif

    // OC stage: load a new op or capture operands as they become available.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            oc_valid_r <= 1'b0;
            oc_first_r <= 1'b0;
            oc_op_r    <= '0;
            a_have_r   <= 1'b0;
            b_have_r   <= 1'b0;
            a_val_r    <= 32'd0;
            b_val_r    <= 32'd0;
        end else if (oc_load_s) begin
            oc_valid_r <= 1'b1;
            oc_first_r <= 1'b1;
            oc_op_r    <= oc_in_s;
            a_have_r   <= 1'b0;
            b_have_r   <= 1'b0;
        end else if (oc_fire_s) begin
            oc_valid_r <= 1'b0;
            oc_first_r <= 1'b0;
        end else begin
            oc_first_r <= 1'b0;
            if (oc_valid_r && a_ready_s && !a_have_r) begin
                a_have_r <= 1'b1;
                a_val_r  <= a_value_s;
            end
            if (oc_valid_r && b_ready_s && !b_have_r) begin
                b_have_r <= 1'b1;
                b_val_r  <= b_value_s;
            end
        end
    end

    // Address, byte mask and shifted data across a two-word window.
    always_comb begin
        addr_s = a_value_s + {{20{oc_op_r.imm[11]}}, oc_op_r.imm};
        case (oc_op_r.size)
            2'b00:   base_s = 8'h01;
            2'b01:   base_s = 8'h03;
            default: base_s = 8'h0F;
        endcase
        mask8_s     = base_s << addr_s[1:0];
        data64_s    = {32'd0, b_value_s} << {addr_s[1:0], 3'b000};
        mis_s       = |mask8_s[7:4];
        waddr_inc_s = {vpn_r, po_r} + WADDR_W'(1);
    end

    // Split FSM and REQ next-state: hold by default, second beat has priority over a new op.
    always_comb begin
        state_n   = state_r;
        valid_n   = valid_r;
        is_mq_n   = is_mq_r;
        mis_n     = mis_r;
        exc_n     = exc_r;
        split_n   = split_r;
        vpn_n     = vpn_r;
        po_n      = po_r;
        mask_n    = mask_r;
        data_n    = data_r;
        cq_n      = cq_r;
        hi_mask_n = hi_mask_r;
        hi_data_n = hi_data_r;
        if (state_r == S_BEAT1 && split_r && REQ_ack) begin
            state_n = S_BEAT2;
            is_mq_n = 1'b1;
            vpn_n   = waddr_inc_s[WADDR_W-1 -: VPN_WIDTH];
            po_n    = waddr_inc_s[PO_WIDTH-3:0];
            mask_n  = hi_mask_r;
            data_n  = hi_data_r;
        end else if (oc_fire_s) begin
            state_n   = S_BEAT1;
            valid_n   = 1'b1;
            is_mq_n   = 1'b0;
            mis_n     = mis_s && !oc_op_r.is_fence;
            exc_n     = mis_s && oc_op_r.is_amo;
            split_n   = mis_s && oc_op_r.is_store;
            vpn_n     = addr_s[PO_WIDTH +: VPN_WIDTH];
            po_n      = addr_s[2 +: PO_WIDTH-2];
            mask_n    = oc_op_r.is_fence ? 4'b0000 : mask8_s[3:0];
            data_n    = oc_op_r.is_fence ? 32'd0 : data64_s[31:0];
            cq_n      = oc_op_r.cq;
            hi_mask_n = mask8_s[7:4];
            hi_data_n = data64_s[63:32];
        end else if (REQ_ack) begin
            state_n = S_IDLE;
            valid_n = 1'b0;
        end else begin
            state_n = state_r;
        end
    end

    // REQ register bank; all REQ outputs come straight from here.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r   <= S_IDLE;
            valid_r   <= 1'b0;
            is_mq_r   <= 1'b0;
            mis_r     <= 1'b0;
            exc_r     <= 1'b0;
            split_r   <= 1'b0;
            vpn_r     <= '0;
            po_r      <= '0;
            mask_r    <= 4'b1111;
            data_r    <= 32'd0;
            cq_r      <= '0;
            hi_mask_r <= 4'b0000;
            hi_data_r <= 32'd0;
        end else begin
            state_r   <= state_n;
            valid_r   <= valid_n;
            is_mq_r   <= is_mq_n;
            mis_r     <= mis_n;
            exc_r     <= exc_n;
            split_r   <= split_n;
            vpn_r     <= vpn_n;
            po_r      <= po_n;
            mask_r    <= mask_n;
            data_r    <= data_n;
            cq_r      <= cq_n;
            hi_mask_r <= hi_mask_n;
            hi_data_r <= hi_data_n;
        end
    end

    assign REQ_valid                = valid_r;
    assign REQ_is_mq                = is_mq_r;
    assign REQ_misaligned           = mis_r;
    assign REQ_misaligned_exception = exc_r;
    assign REQ_VPN                  = vpn_r;
    assign REQ_PO_word              = po_r;
    assign REQ_byte_mask            = mask_r;
    assign REQ_write_data           = data_r;
    assign REQ_cq_index             = cq_r;
endmodule

// File: tb/tb_stamofu_split_addr_pipeline.sv
// Scoreboard bench for stamofu_split_addr_pipeline: expected beats are queued at issue time and
// compared whenever the DUT hands over a beat.
module tb_stamofu_split_addr_pipeline;
    logic CLK = 1'b0;
    logic nRST;
    logic issue_valid, issue_is_store, issue_is_amo, issue_is_fence;
    logic [3:0] issue_op;
    logic [11:0] issue_imm12;
    logic issue_A_forward, issue_A_is_zero, issue_B_forward, issue_B_is_zero;
    logic [1:0] issue_A_bank, issue_B_bank;
    logic [3:0] issue_cq_index;
    logic issue_ready;
    logic A_reg_read_ack, A_reg_read_port, B_reg_read_ack, B_reg_read_port;
    logic [3:0][1:0][31:0] rr_arr;
    logic [3:0][31:0] fwd_arr;
    logic REQ_valid, REQ_is_mq, REQ_misaligned, REQ_misaligned_exception;
    logic [19:0] REQ_VPN;
    logic [9:0] REQ_PO_word;
    logic [3:0] REQ_byte_mask;
    logic [31:0] REQ_write_data;
    logic [3:0] REQ_cq_index;
    logic REQ_ack;

    typedef struct packed {
        logic        is_mq;
        logic        mis;
        logic        exc;
        logic [19:0] vpn;
        logic [9:0]  po;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [3:0]  cq;
    } beat_t;

    beat_t exp_q[$];
    beat_t act;
    int checks = 0;
    int errors = 0;

    stamofu_split_addr_pipeline dut (
        .CLK(CLK), .nRST(nRST),
        .issue_valid(issue_valid), .issue_is_store(issue_is_store), .issue_is_amo(issue_is_amo),
        .issue_is_fence(issue_is_fence), .issue_op(issue_op), .issue_imm12(issue_imm12),
        .issue_A_forward(issue_A_forward), .issue_A_is_zero(issue_A_is_zero), .issue_A_bank(issue_A_bank),
        .issue_B_forward(issue_B_forward), .issue_B_is_zero(issue_B_is_zero), .issue_B_bank(issue_B_bank),
        .issue_cq_index(issue_cq_index), .issue_ready(issue_ready),
        .A_reg_read_ack(A_reg_read_ack), .A_reg_read_port(A_reg_read_port),
        .B_reg_read_ack(B_reg_read_ack), .B_reg_read_port(B_reg_read_port),
        .reg_read_data_by_bank_by_port(rr_arr), .forward_data_by_bank(fwd_arr),
        .REQ_valid(REQ_valid), .REQ_is_mq(REQ_is_mq), .REQ_misaligned(REQ_misaligned),
        .REQ_misaligned_exception(REQ_misaligned_exception), .REQ_VPN(REQ_VPN),
        .REQ_PO_word(REQ_PO_word), .REQ_byte_mask(REQ_byte_mask), .REQ_write_data(REQ_write_data),
        .REQ_cq_index(REQ_cq_index), .REQ_ack(REQ_ack)
    );

    always #5 CLK = ~CLK;

    assign act = '{is_mq: REQ_is_mq, mis: REQ_misaligned, exc: REQ_misaligned_exception,
                   vpn: REQ_VPN, po: REQ_PO_word, mask: REQ_byte_mask, data: REQ_write_data,
                   cq: REQ_cq_index};

    // Scoreboard: every handed-over beat must match the oldest expected one.
    always @(negedge CLK) begin
        if (nRST && REQ_valid && REQ_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got %h, expected no beat", act);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL beat: got %h, expected %h", act, e);
                end
            end
        end
    end

    function automatic beat_t mk(input logic is_mq, mis, exc, input logic [19:0] vpn,
                                 input logic [9:0] po, input logic [3:0] mask,
                                 input logic [31:0] data, input logic [3:0] cq);
        return '{is_mq: is_mq, mis: mis, exc: exc, vpn: vpn, po: po, mask: mask, data: data, cq: cq};
    endfunction

    // Offer one op and hold it until accepted (bounded).
    task automatic do_issue(input logic st, am, fe, input logic [1:0] sz, input logic [11:0] imm,
                            input logic af, az, input logic [1:0] ab,
                            input logic bf, bz, input logic [1:0] bb, input logic [3:0] cq);
        int n;
        issue_is_store = st; issue_is_amo = am; issue_is_fence = fe;
        issue_op = {2'b00, sz}; issue_imm12 = imm;
        issue_A_forward = af; issue_A_is_zero = az; issue_A_bank = ab;
        issue_B_forward = bf; issue_B_is_zero = bz; issue_B_bank = bb;
        issue_cq_index = cq; issue_valid = 1'b1;
        n = 0;
        @(negedge CLK);
        while (!issue_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL issue_timeout: issue_ready stayed %b, expected 1", issue_ready);
        end
        @(posedge CLK);
        #1 issue_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        idle(2);
        @(negedge CLK);
        checks++; if (REQ_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", REQ_valid); end
        checks++; if (REQ_byte_mask !== 4'b1111) begin errors++; $display("FAIL rst_mask: got %b, expected 1111", REQ_byte_mask); end
        checks++; if (REQ_VPN !== 20'd0 || REQ_PO_word !== 10'd0) begin errors++; $display("FAIL rst_addr: got %h/%h, expected 0/0", REQ_VPN, REQ_PO_word); end
        checks++; if (REQ_write_data !== 32'd0) begin errors++; $display("FAIL rst_data: got %h, expected 0", REQ_write_data); end
        checks++; if ({REQ_is_mq, REQ_misaligned, REQ_misaligned_exception} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b, expected 000", {REQ_is_mq, REQ_misaligned, REQ_misaligned_exception}); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_issue_ready: got %b, expected 1", issue_ready); end
        @(posedge CLK);
        #1 nRST = 1'b1;
        idle(1);
    endtask

    task automatic test_aligned_store;
        fwd_arr[1] = 32'h0000_1000;
        rr_arr[2][1] = 32'h1234_5678;
        REQ_ack = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 20'h00001, 10'h001, 4'b1111, 32'h1234_5678, 4'd1));
        do_issue(1'b1, 1'b0, 1'b0, 2'b10, 12'h004, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 2'd2, 4'd1);
        B_reg_read_ack = 1'b1; B_reg_read_port = 1'b1;
        @(negedge CLK);
        checks++; if (REQ_valid !== 1'b0) begin errors++; $display("FAIL latency_n1: got %b, expected 0", REQ_valid); end
        @(posedge CLK);
        #1 B_reg_read_ack = 1'b0;
        @(negedge CLK);
        checks++; if (REQ_valid !== 1'b1) begin errors++; $display("FAIL latency_n2: got %b, expected 1", REQ_valid); end
        idle(2);
    endtask

    task automatic test_half_store;
        fwd_arr[3] = 32'h0000_BEEF;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 20'h00001, 10'h000, 4'b1100, 32'hBEEF_0000, 4'd2));
        do_issue(1'b1, 1'b0, 1'b0, 2'b01, 12'h002, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 2'd3, 4'd2);
        idle(4);
    endtask

    task automatic test_split_page_carry;
        fwd_arr[0] = 32'h0000_2FFE;
        fwd_arr[3] = 32'hAABB_CCDD;
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 20'h00002, 10'h3FF, 4'b1000, 32'hDD00_0000, 4'd3));
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 20'h00003, 10'h000, 4'b0111, 32'h00AA_BBCC, 4'd3));
        do_issue(1'b1, 1'b0, 1'b0, 2'b10, 12'h001, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd3, 4'd3);
        idle(5);
    endtask

    task automatic test_misaligned_amo;
        fwd_arr[3] = 32'hCAFE_F00D;
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 20'h00001, 10'h000, 4'b1100, 32'hF00D_0000, 4'd4));
        do_issue(1'b0, 1'b1, 1'b0, 2'b10, 12'h002, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 2'd3, 4'd4);
        idle(5);
    endtask

    task automatic test_fence;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 20'h00001, 10'h002, 4'b0000, 32'h0000_0000, 4'd6));
        do_issue(1'b0, 1'b0, 1'b1, 2'b10, 12'h008, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 2'd0, 4'd6);
        idle(4);
    endtask

    task automatic test_backpressure;
        REQ_ack = 1'b0;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 20'h00001, 10'h001, 4'b0010, 32'hFEF0_0D00, 4'd7));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 20'h00001, 10'h004, 4'b1111, 32'hCAFE_F00D, 4'd8));
        do_issue(1'b1, 1'b0, 1'b0, 2'b00, 12'h005, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 2'd3, 4'd7);
        do_issue(1'b1, 1'b0, 1'b0, 2'b10, 12'h010, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 2'd3, 4'd8);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++; if (REQ_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, expected 1", REQ_valid); end
            checks++; if (REQ_byte_mask !== 4'b0010 || REQ_PO_word !== 10'h001) begin errors++; $display("FAIL bp_hold: got mask %b po %h, expected 0010/001", REQ_byte_mask, REQ_PO_word); end
            checks++; if (REQ_write_data !== 32'hFEF0_0D00) begin errors++; $display("FAIL bp_data: got %h, expected fef00d00", REQ_write_data); end
            checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL bp_issue_ready: got %b, expected 0", issue_ready); end
            @(posedge CLK);
            #1;
        end
        REQ_ack = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        checks++; if (REQ_valid !== 1'b1 || REQ_PO_word !== 10'h004) begin errors++; $display("FAIL bp_next: got valid %b po %h, expected 1/004", REQ_valid, REQ_PO_word); end
        idle(3);
    endtask

    task automatic test_back_to_back;
        REQ_ack = 1'b1;
        for (int i = 0; i < 3; i++)
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 20'h00001, 10'(8 + i), 4'b1111, 32'hCAFE_F00D, 4'(9 + i)));
        for (int i = 0; i < 3; i++)
            do_issue(1'b1, 1'b0, 1'b0, 2'b10, 12'(32 + 4 * i), 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 2'd3, 4'(9 + i));
        @(posedge CLK);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d beats pending, expected 0", exp_q.size()); end
        idle(6);
    endtask

    task automatic test_reset_mid_split;
        REQ_ack = 1'b1;
        fwd_arr[3] = 32'hAABB_CCDD;
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 20'h00002, 10'h3FF, 4'b1000, 32'hDD00_0000, 4'd5));
        do_issue(1'b1, 1'b0, 1'b0, 2'b10, 12'h001, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd3, 4'd5);
        @(posedge CLK);
        @(posedge CLK);
        #1 REQ_ack = 1'b0; nRST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        checks++; if (REQ_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b, expected 0", REQ_valid); end
        checks++; if (REQ_byte_mask !== 4'b1111 || REQ_is_mq !== 1'b0) begin errors++; $display("FAIL mid_rst_mask: got %b mq %b, expected 1111/0", REQ_byte_mask, REQ_is_mq); end
        checks++; if (REQ_VPN !== 20'd0 || REQ_write_data !== 32'd0 || REQ_cq_index !== 4'd0) begin errors++; $display("FAIL mid_rst_fields: got %h/%h/%h, expected 0/0/0", REQ_VPN, REQ_write_data, REQ_cq_index); end
        checks++; if (REQ_misaligned !== 1'b0) begin errors++; $display("FAIL mid_rst_mis: got %b, expected 0", REQ_misaligned); end
        @(posedge CLK);
        #1 nRST = 1'b1; REQ_ack = 1'b1;
        idle(6);
    endtask

    initial begin
        nRST = 1'b0; issue_valid = 1'b0; issue_is_store = 1'b0; issue_is_amo = 1'b0; issue_is_fence = 1'b0;
        issue_op = 4'd0; issue_imm12 = 12'd0; issue_A_forward = 1'b0; issue_A_is_zero = 1'b0;
        issue_A_bank = 2'd0; issue_B_forward = 1'b0; issue_B_is_zero = 1'b0; issue_B_bank = 2'd0;
        issue_cq_index = 4'd0; A_reg_read_ack = 1'b0; A_reg_read_port = 1'b0;
        B_reg_read_ack = 1'b0; B_reg_read_port = 1'b0; REQ_ack = 1'b0;
        rr_arr = '0; fwd_arr = '0;
        test_reset();
        test_aligned_store();
        test_half_store();
        test_split_page_carry();
        test_misaligned_amo();
        test_fence();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_split();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: got %0d beats pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stamofu_split_addr_pipeline.md
Name: stamofu_split_addr_pipeline

Overview:
- Parametrised successor to the store/AMO/fence address pipeline.
- Two stages:
  - OC (operand collect): gathers A/B from forward, register read or zero.
  - REQ: generates address, byte mask and aligned write data.
- Misaligned stores crossing a word boundary are split into two sequential REQ beats instead of a single flagged beat.
- Sits between the stamofu issue queue / PRF and the stamofu CQ / dTLB request path.

Parameters:
PRF_BANK_COUNT, 4, number of PRF banks
LOG_PRF_BANK_COUNT, 2, log2(PRF_BANK_COUNT)
LOG_CQ_ENTRIES, 4, width of CQ index
VPN_WIDTH, 20, virtual page number width
PO_WIDTH, 12, page offset width

Ports:
CLK  in  1  clock
nRST  in  1  synchronous active-low reset
issue_valid  in  1  op offered by IQ
issue_is_store / issue_is_amo / issue_is_fence  in  1 each  op class (one-hot when valid)
issue_op  in  4  op[1:0] size: 00 byte, 01 half, 10 word; 11 reserved, treated as word
issue_imm12  in  12  signed offset
issue_A_forward / issue_A_is_zero  in  1 each  A source select
issue_A_bank  in  LOG_PRF_BANK_COUNT  A bank
issue_B_forward / issue_B_is_zero / issue_B_bank  in  1/1/LOG_PRF_BANK_COUNT  B source
issue_cq_index  in  LOG_CQ_ENTRIES  CQ entry
issue_ready  out  1  OC can accept
A_reg_read_ack / A_reg_read_port  in  1/1  A read data present this cycle on given port
B_reg_read_ack / B_reg_read_port  in  1/1  same for B
reg_read_data_by_bank_by_port  in  PRF_BANK_COUNT*2*32  read data
forward_data_by_bank  in  PRF_BANK_COUNT*32  forward data
REQ_valid  out  1  request beat valid
REQ_is_mq  out  1  beat is second half of a split (goes to misaligned queue)
REQ_misaligned  out  1  op crosses word boundary
REQ_misaligned_exception  out  1  misaligned AMO, no memory access
REQ_VPN  out  VPN_WIDTH
REQ_PO_word  out  PO_WIDTH-2
REQ_byte_mask  out  4
REQ_write_data  out  32
REQ_cq_index  out  LOG_CQ_ENTRIES
REQ_ack  in  1  consumer accepts current beat

Behaviour:
- Reset (nRST=0 at posedge):
  - Outputs: REQ_valid=0, REQ_is_mq=0, REQ_misaligned=0, REQ_misaligned_exception=0, VPN=0, PO_word=0, byte_mask=4'b1111, write_data=0, cq_index=0.
  - State: OC empty, split FSM IDLE. issue_ready=1 out of reset.
- Issue: accept on issue_valid & issue_ready; op enters OC next cycle.
- OC operand capture, per operand, sticky once captured:
  - is_zero: value 0, ready immediately.
  - forward: capture forward_data_by_bank[bank] in the first OC cycle only.
  - otherwise: capture reg_read_data_by_bank_by_port[bank][port] in the cycle reg_read_ack=1; wait indefinitely.
  - Fence: both operands treated as ready.
- OC fires to REQ when both operands are ready and REQ is free or its last beat is acked this cycle.
- Minimum latency: issue at cycle N gives REQ_valid at N+2.
- issue_ready = ~OC_valid | OC_fire (combinational without the optional feature).
- Address: addr = A + sext(imm12), 32-bit wrap. VPN = addr[31:12], PO_word = addr[11:2], off = addr[1:0].
- Mask and data:
  - mask8 = base << off, where base = 0001 (byte), 0011 (half), 1111 (word).
  - data64 = {32'b0, B} << (8*off).
  - misaligned = |mask8[7:4].
- Split FSM, states IDLE → BEAT1 → BEAT2:
  - Aligned store: one beat with mask8[3:0], data64[31:0], is_mq=0.
  - Misaligned store: BEAT1 at addr word with mask8[3:0], data64[31:0]. On REQ_ack, BEAT2 with {VPN,PO_word}+1 (carries into VPN; VPN all-ones wraps to 0), mask8[7:4], data64[63:32], is_mq=1. REQ_misaligned=1 on both beats.
  - Misaligned AMO: single beat, misaligned=1, misaligned_exception=1, mask8[3:0].
  - Fence: single beat, byte_mask=4'b0000, data 0, address computed as normal.
- Backpressure: while REQ_valid & ~REQ_ack, all REQ outputs are held stable. OC holds; issue_ready=0 if OC is occupied.
- Back-to-back: an op may enter REQ in the same cycle the previous final beat is acked (no bubble).
- Reset mid-split: the pending BEAT2 is discarded; REQ_valid=0 the cycle after reset.

Optional Feature:
- Macro: STAMOFU_SPLIT_ADDR_PIPELINE_SKID_EN.
- Defined:
  - A one-entry skid register sits in front of OC.
  - issue_ready is a pure flop output (= skid empty), with no combinational path from REQ_ack.
  - Adds zero latency when the skid is empty; one extra cycle only while draining the skid.
- Undefined: combinational issue_ready as above.
- Either build must produce an identical REQ beat sequence for identical stimulus (timing may differ by skid drain).

Test Plan:
- Aligned store: sw, A=0x00001000 via forward bank1, imm=0x004, B=0x12345678 via reg read bank2 port1 ack in first OC cycle → at N+2: REQ_valid=1, VPN=0x00001, PO_word=0x001, mask=1111, data=0x12345678, misaligned=0.
- Half store: sh at addr 0x00001002, B=0x0000BEEF → mask=1100, data=0xBEEF0000, single beat.
- Split with page carry: sw, A=0x00002FFE, imm=0x001, B=0xAABBCCDD →
  - BEAT1: VPN=0x00002, PO_word=0x3FF, mask=1000, data=0xDD000000, is_mq=0, misaligned=1.
  - After ack, BEAT2: VPN=0x00003, PO_word=0x000, mask=0111, data=0x00AABBCC, is_mq=1.
- Misaligned AMO word at addr 0x00001002 → one beat, misaligned=1, misaligned_exception=1, mask=1100; no second beat.
- Backpressure: REQ_ack=0 for 3 cycles with a second op waiting in OC → REQ outputs unchanged, issue_ready=0; ack → next op valid in the following cycle.
- Reset after BEAT1 acked → REQ_valid=0 and all outputs at reset values next cycle, no BEAT2 ever appears.
